// File: rtl/bridge_pkg.sv
// Shared types and helpers for the SRAM-like to AXI bridge: FSM state encoding,
// fixed AXI burst attributes and the byte-strobe function.
package bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrAddrData,
    StWrResp
  } bridge_state_e;

  localparam logic [7:0] AxiLen       = 8'd0;
  localparam logic [1:0] AxiBurstIncr = 2'b01;
  localparam logic [1:0] AxiLock      = 2'b00;
  localparam logic [3:0] AxiCache     = 4'b0000;
  localparam logic [2:0] AxiProt      = 3'b000;

  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

  // Size 3 is not a legal SRAM-like size; it falls back to a full-word strobe.
  function automatic logic [3:0] wstrb_of(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << addr_lo;
      2'd1:    strb = 4'b0011 << addr_lo;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/sram_like_axi_bridge.sv
// Bridges SRAM-like instruction/data ports onto a single-outstanding AXI master.
// Define INST_PORT_EN to enable the instruction port and its arbitration against data.
module sram_like_axi_bridge
  import bridge_pkg::*;
#(
  parameter int unsigned AXI_ID_W = 4,
  parameter int unsigned INST_ID  = 0,
  parameter int unsigned DATA_ID  = 1
) (
  input  logic                clock,
  input  logic                reset,

  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [31:0]         inst_addr,
  input  logic [31:0]         inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [31:0]         inst_rdata,

  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [31:0]         data_addr,
  input  logic [31:0]         data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [31:0]         data_rdata,

  output logic [AXI_ID_W-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,

  input  logic [AXI_ID_W-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,

  output logic [AXI_ID_W-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,

  output logic [AXI_ID_W-1:0] wid,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,

  input  logic [AXI_ID_W-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam logic [AXI_ID_W-1:0] InstId = AXI_ID_W'(INST_ID);
  localparam logic [AXI_ID_W-1:0] DataId = AXI_ID_W'(DATA_ID);

  bridge_state_e state_q, state_d;
  logic          owner_inst_q, owner_inst_d;
  logic [1:0]    size_q, size_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic          data_ok_q, data_ok_d;
  logic          inst_ok_q, inst_ok_d;
  logic [31:0]   data_rdata_q, data_rdata_d;
  logic [31:0]   inst_rdata_q, inst_rdata_d;

  logic          idle_free, grant_data, grant_inst;
  logic          req_wr;
  logic [1:0]    req_size;
  logic [31:0]   req_addr, req_wdata;
  logic          aw_fire, w_fire;

  // No new grant while a data_ok pulse is on the wire, even though the FSM is idle.
  assign idle_free  = (state_q == StIdle) && !data_ok_q && !inst_ok_q && !reset;
  assign grant_data = idle_free && data_req;

`ifdef INST_PORT_EN
  assign grant_inst   = idle_free && inst_req && !data_req;
  assign req_wr       = grant_inst ? inst_wr    : data_wr;
  assign req_size     = grant_inst ? inst_size  : data_size;
  assign req_addr     = grant_inst ? inst_addr  : data_addr;
  assign req_wdata    = grant_inst ? inst_wdata : data_wdata;
  assign inst_addr_ok = grant_inst;
  assign inst_data_ok = inst_ok_q;
  assign inst_rdata   = inst_rdata_q;
`else
  assign grant_inst   = 1'b0;
  assign req_wr       = data_wr;
  assign req_size     = data_size;
  assign req_addr     = data_addr;
  assign req_wdata    = data_wdata;
  assign inst_addr_ok = 1'b0;
  assign inst_data_ok = 1'b0;
  assign inst_rdata   = '0;

  logic unused_inst;
  assign unused_inst = ^{inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
                         inst_ok_q, inst_rdata_q};
`endif

  logic unused_axi;
  assign unused_axi = ^{rid, rresp, rlast, bid, bresp};

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;

  always_comb begin
    state_d      = state_q;
    owner_inst_d = owner_inst_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    data_ok_d    = 1'b0;
    inst_ok_d    = 1'b0;
    data_rdata_d = data_rdata_q;
    inst_rdata_d = inst_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant_data || grant_inst) begin
          owner_inst_d = grant_inst;
          size_d       = req_size;
          addr_d       = req_addr;
          wdata_d      = req_wdata;
          aw_done_d    = 1'b0;
          w_done_d     = 1'b0;
          state_d      = req_wr ? StWrAddrData : StRdAddr;
        end
      end
      StRdAddr: begin
        if (arready) state_d = StRdData;
      end
      StRdData: begin
        if (rvalid) begin
          state_d = StIdle;
          if (owner_inst_q) begin
            inst_ok_d    = 1'b1;
            inst_rdata_d = rdata;
          end else begin
            data_ok_d    = 1'b1;
            data_rdata_d = rdata;
          end
        end
      end
      StWrAddrData: begin
        if (aw_fire) aw_done_d = 1'b1;
        if (w_fire)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = StWrResp;
      end
      StWrResp: begin
        if (bvalid) begin
          state_d = StIdle;
          if (owner_inst_q) inst_ok_d = 1'b1;
          else              data_ok_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_inst_q <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      data_ok_q    <= 1'b0;
      inst_ok_q    <= 1'b0;
      data_rdata_q <= '0;
      inst_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_inst_q <= owner_inst_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      data_ok_q    <= data_ok_d;
      inst_ok_q    <= inst_ok_d;
      data_rdata_q <= data_rdata_d;
      inst_rdata_q <= inst_rdata_d;
    end
  end

  assign data_addr_ok = grant_data;
  assign data_data_ok = data_ok_q;
  assign data_rdata   = data_rdata_q;

  assign arid    = owner_inst_q ? InstId : DataId;
  assign araddr  = addr_q;
  assign arlen   = AxiLen;
  assign arsize  = axi_size(size_q);
  assign arburst = AxiBurstIncr;
  assign arlock  = AxiLock;
  assign arcache = AxiCache;
  assign arprot  = AxiProt;
  assign arvalid = (state_q == StRdAddr);
  assign rready  = (state_q == StRdData);

  assign awid    = DataId;
  assign awaddr  = addr_q;
  assign awlen   = AxiLen;
  assign awsize  = axi_size(size_q);
  assign awburst = AxiBurstIncr;
  assign awlock  = AxiLock;
  assign awcache = AxiCache;
  assign awprot  = AxiProt;
  assign awvalid = (state_q == StWrAddrData) && !aw_done_q;

  assign wid    = DataId;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_of(size_q, addr_q[1:0]);
  assign wlast  = 1'b1;
  assign wvalid = (state_q == StWrAddrData) && !w_done_q;

  assign bready = (state_q == StWrResp);

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// Scoreboard bench for sram_like_axi_bridge: directed transactions push expectations,
// a negedge monitor pops and compares on every AXI handshake and data_ok pulse.
module tb_sram_like_axi_bridge;

  localparam logic [3:0] DataId = 4'd1;
  localparam logic [3:0] InstId = 4'd0;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic        inst_req = 1'b0, inst_wr = 1'b0;
  logic [1:0]  inst_size = '0;
  logic [31:0] inst_addr = '0, inst_wdata = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = '0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  logic [3:0]  arid, awid, wid;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, awvalid, wvalid, wlast, rready, bready;
  logic        arready = 1'b0, awready = 1'b0, wready = 1'b0;
  logic [3:0]  rid = '0, bid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0, bresp = '0;
  logic        rlast = 1'b0, rvalid = 1'b0, bvalid = 1'b0;

  sram_like_axi_bridge #(
    .AXI_ID_W(4),
    .INST_ID (0),
    .DATA_ID (1)
  ) dut (
    .clock(clock), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int bready_rises = 0;

  logic [38:0] exp_ar[$];    // {id, addr, size}
  logic [34:0] exp_aw[$];    // {addr, size}
  logic [35:0] exp_w[$];     // {data, strb}
  logic [32:0] exp_drsp[$];  // {is_read, rdata}
  logic [31:0] exp_irsp[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting, required an event within budget", name);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: sample away from the rising edge and pop expectations on every event.
  initial begin
    logic [38:0] ea;
    logic [34:0] eaw;
    logic [35:0] ew;
    logic [32:0] ed;
    logic        bready_prev;
    bready_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (arvalid && arready) begin
          if (exp_ar.size() == 0) check("ar_unexpected", 1'b1, 1'b0);
          else begin
            ea = exp_ar.pop_front();
            check("ar_fields", {arid, araddr, arsize, arlen, arburst, arlock, arcache, arprot},
                  {ea, 8'h00, 2'b01, 2'b00, 4'h0, 3'h0});
          end
        end
        if (awvalid && awready) begin
          if (exp_aw.size() == 0) check("aw_unexpected", 1'b1, 1'b0);
          else begin
            eaw = exp_aw.pop_front();
            check("aw_fields", {awid, awaddr, awsize, awlen, awburst, awlock, awcache, awprot},
                  {DataId, eaw, 8'h00, 2'b01, 2'b00, 4'h0, 3'h0});
          end
        end
        if (wvalid && wready) begin
          if (exp_w.size() == 0) check("w_unexpected", 1'b1, 1'b0);
          else begin
            ew = exp_w.pop_front();
            check("w_fields", {wid, wdata, wstrb, wlast}, {DataId, ew, 1'b1});
          end
        end
        if (data_data_ok) begin
          check("no_addr_ok_during_data_ok", {data_addr_ok, inst_addr_ok}, 2'b00);
          if (exp_drsp.size() == 0) check("data_ok_unexpected", 1'b1, 1'b0);
          else begin
            ed = exp_drsp.pop_front();
            if (ed[32]) check("data_rdata", data_rdata, ed[31:0]);
          end
        end
        if (inst_data_ok) begin
          if (exp_irsp.size() == 0) check("inst_ok_unexpected", 1'b1, 1'b0);
          else check("inst_rdata", inst_rdata, exp_irsp.pop_front());
        end
        if (bready && !bready_prev) bready_rises++;
      end
      bready_prev = bready;
    end
  end

  task automatic issue_data(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wd);
    int n;
    n = 0;
    data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
    #1;
    while (!data_addr_ok && n < 20) begin
      tick();
      n++;
    end
    if (!data_addr_ok) timeout("data_addr_ok");
    tick();
    data_req = 1'b0;
  endtask

  task automatic ar_slave(input int delay);
    int n;
    n = 0;
    while (!arvalid && n < 20) begin
      tick();
      n++;
    end
    if (!arvalid) begin
      timeout("arvalid");
      return;
    end
    repeat (delay) tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  task automatic r_slave(input logic [31:0] d, input logic [3:0] id);
    int n;
    n = 0;
    rvalid = 1'b1; rdata = d; rid = id; rresp = 2'b10; rlast = 1'b1;
    while (!rready && n < 20) begin
      tick();
      n++;
    end
    if (!rready) timeout("rready");
    else tick();
    rvalid = 1'b0; rdata = '0; rlast = 1'b0;
  endtask

  task automatic wr_slave(input int w_delay, input int aw_delay);
    int n;
    int last;
    n = 0;
    last = (w_delay > aw_delay) ? w_delay : aw_delay;
    while (!awvalid && n < 20) begin
      tick();
      n++;
    end
    if (!awvalid) begin
      timeout("awvalid");
      return;
    end
    for (int c = 0; c <= last; c++) begin
      awready = (c == aw_delay);
      wready  = (c == w_delay);
      tick();
    end
    awready = 1'b0; wready = 1'b0;
    // Mismatched bid and an error response must not stop completion.
    bvalid = 1'b1; bid = 4'hF; bresp = 2'b11;
    n = 0;
    while (!bready && n < 20) begin
      tick();
      n++;
    end
    if (!bready) timeout("bready");
    else tick();
    bvalid = 1'b0;
  endtask

  task automatic data_read(input logic [31:0] addr, input logic [1:0] size, input int ar_delay,
                           input logic [31:0] rd);
    exp_ar.push_back({DataId, addr, 1'b0, size});
    exp_drsp.push_back({1'b1, rd});
    issue_data(1'b0, size, addr, 32'h0);
    ar_slave(ar_delay);
    r_slave(rd, 4'h7);
  endtask

  task automatic data_write(input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] wd, input logic [3:0] strb,
                            input int w_delay, input int aw_delay);
    int rises;
    rises = bready_rises;
    exp_aw.push_back({addr, 1'b0, size});
    exp_w.push_back({wd, strb});
    exp_drsp.push_back({1'b0, 32'h0});
    issue_data(1'b1, size, addr, wd);
    wr_slave(w_delay, aw_delay);
    check("wr_resp_entries", bready_rises - rises, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int viol;
    #1;
    check("reset_outputs_t0", {arvalid, rready, awvalid, wvalid, bready, data_addr_ok,
          data_data_ok, data_rdata, inst_addr_ok, inst_data_ok, inst_rdata, araddr}, '0);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Stray responses while idle are ignored.
    rvalid = 1'b1; bvalid = 1'b1; rdata = 32'h55AA55AA;
    for (int i = 0; i < 3; i++) begin
      check("stray_ready_low", {rready, bready, data_data_ok}, 3'b000);
      tick();
    end
    rvalid = 1'b0; bvalid = 1'b0; rdata = '0;

    data_read(32'h1000_0004, 2'd2, 2, 32'hDEAD_BEEF);
    data_read(32'h1000_0010, 2'd2, 0, 32'h0BAD_F00D);
    data_write(32'h2000_0003, 2'd0, 32'h1122_3344, 4'b1000, 0, 3);
    data_write(32'h2000_0002, 2'd1, 32'hAABB_CCDD, 4'b1100, 2, 0);
    data_write(32'h2000_0001, 2'd1, 32'h0102_0304, 4'b0110, 0, 0);
    data_write(32'h2000_0008, 2'd2, 32'hFFFF_0000, 4'b1111, 1, 1);
    data_write(32'h2000_000C, 2'd3, 32'h8765_4321, 4'b1111, 1, 0);
    data_read(32'h1000_0001, 2'd0, 1, 32'h0000_00AB);

    // Reset while waiting for read data abandons the access.
    exp_ar.push_back({DataId, 32'h1000_0040, 3'b010});
    issue_data(1'b0, 2'd2, 32'h1000_0040, 32'h0);
    ar_slave(0);
    check("in_rd_data", rready, 1'b1);
    reset = 1'b1;
    #1;
    check("reset_mid_read", {arvalid, rready, awvalid, wvalid, bready, data_addr_ok,
          data_data_ok, data_rdata, inst_addr_ok, inst_data_ok, araddr}, '0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    data_read(32'h1000_0020, 2'd2, 1, 32'hCAFE_F00D);

`ifdef INST_PORT_EN
    exp_ar.push_back({DataId, 32'h3000_0000, 3'b010});
    exp_drsp.push_back({1'b1, 32'hA5A5_5A5A});
    exp_ar.push_back({InstId, 32'h0000_0100, 3'b010});
    exp_irsp.push_back(32'h0000_0013);
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h0000_0100;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h3000_0000;
    #1;
    check("arb_data_wins", {data_addr_ok, inst_addr_ok}, 2'b10);
    tick();
    data_req = 1'b0;
    ar_slave(0);
    r_slave(32'hA5A5_5A5A, DataId);
    viol = 0;
    while (!inst_addr_ok && viol < 20) begin
      tick();
      viol++;
    end
    if (!inst_addr_ok) timeout("inst_addr_ok");
    tick();
    inst_req = 1'b0;
    ar_slave(1);
    r_slave(32'h0000_0013, InstId);
`else
    viol = 0;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h0000_0100;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (inst_addr_ok || inst_data_ok || arvalid) viol++;
    end
    inst_req = 1'b0;
    check("inst_port_ignored", viol, 0);
`endif

    repeat (4) tick();
    check("queues_drained", exp_ar.size() + exp_aw.size() + exp_w.size() + exp_drsp.size()
          + exp_irsp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_like_axi_bridge.md
SRAM_LIKE_AXI_BRIDGE -- requirements
Module: sram_like_axi_bridge

Interface
REQ-001 Parameter AXI_ID_W, default 4, SHALL set the width of the AXI ID fields.
REQ-002 Parameter INST_ID, default 0, SHALL be the ARID for instruction reads.
REQ-003 Parameter DATA_ID, default 1, SHALL be the ARID/AWID for data accesses.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high; ports SHALL be named clock and reset.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 inst_req/inst_wr  in  1/1  instruction sram-like request and write flag.
REQ-008 inst_size/inst_addr/inst_wdata  in  2/32/32  instruction request fields.
REQ-009 inst_addr_ok/inst_data_ok/inst_rdata  out  1/1/32  instruction responses.
REQ-010 data_req/data_wr  in  1/1  data sram-like request and write flag.
REQ-011 data_size/data_addr/data_wdata  in  2/32/32  data request fields.
REQ-012 data_addr_ok/data_data_ok/data_rdata  out  1/1/32  data responses.
REQ-013 arid/araddr/arsize/arvalid  out  AXI_ID_W/32/3/1  read-address channel; arready  in  1.
REQ-014 arlen/arburst/arlock/arcache/arprot  out  8/2/2/4/3  constants 0/01/0/0/0.
REQ-015 rid/rdata/rresp/rlast/rvalid  in  AXI_ID_W/32/2/1/1; rready  out  1.
REQ-016 awid/awaddr/awsize/awvalid  out; awready  in; aw constants as REQ-014.
REQ-017 wid/wdata/wstrb/wlast/wvalid  out  AXI_ID_W/32/4/1/1; wready  in.
REQ-018 bid/bresp/bvalid  in; bready  out.

Function
REQ-019 The FSM SHALL have states IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, with at most one AXI transaction outstanding.
REQ-020 In IDLE, *_addr_ok SHALL assert combinationally for the granted requester; the request fields SHALL be latched on that edge.
REQ-021 When inst_req and data_req are both high in IDLE, data SHALL win; inst_addr_ok SHALL stay 0.
REQ-022 A read grant -> RD_ADDR: arvalid=1 until arready, then RD_DATA.
REQ-023 In RD_DATA, rready=1; on rvalid, *_data_ok SHALL pulse for exactly one cycle with *_rdata=rdata, then IDLE.
REQ-024 A write grant -> WR_ADDR_DATA: awvalid and wvalid SHALL rise together, each drop on its own handshake, and state -> WR_RESP once both have completed (same or different cycles).
REQ-025 In WR_RESP, bready=1; on bvalid, data_data_ok SHALL pulse one cycle, then IDLE.
REQ-026 wstrb SHALL be: size 0 -> 0001<<addr[1:0]; size 1 -> 0011<<addr[1:0]; size 2 -> 1111; size 3 is illegal -> 1111.
REQ-027 ar/awsize SHALL be {0,size}; ar/awaddr SHALL be the latched address unmodified; wlast SHALL be 1.
REQ-028 rresp/bresp SHALL be ignored; an rid/bid mismatch SHALL still complete the access.
REQ-029 rready/bready SHALL be 0 outside RD_DATA/WR_RESP; stray rvalid/bvalid SHALL be ignored.
REQ-030 No addr_ok SHALL assert outside IDLE, including the cycle data_ok pulses.

Reset
REQ-031 Reset SHALL force IDLE, all valid/ready/ok outputs to 0, and latched fields and *_rdata to 0.
REQ-032 Reset mid-transaction SHALL abandon it; the AXI slave SHALL be reset concurrently.

Configuration
REQ-033 With INST_PORT_EN defined, the instruction port and arbitration SHALL be present.
REQ-034 Without INST_PORT_EN, inst_addr_ok/inst_data_ok/inst_rdata SHALL be constant 0, inst inputs SHALL be unused, and data SHALL be granted unconditionally.

Structure
REQ-035 FSM state encoding, AXI burst/size constants and the wstrb function SHALL live in package bridge_pkg.
REQ-036 No sub-module is required; the single FSM SHALL reside in sram_like_axi_bridge.

Verification
REQ-037 Data read at 0x1000_0004, arready delayed 2 cycles, rdata=0xDEADBEEF -> araddr=0x1000_0004, arid=1, data_data_ok pulses once with data_rdata=0xDEADBEEF.
REQ-038 Byte write size 0 at addr 0x...3, wdata 0x11223344 -> wstrb=1000, awsize=000; wready precedes awready by 3 cycles -> single WR_RESP entry, data_data_ok after bvalid.
REQ-039 inst_req and data_req high together -> data_addr_ok=1, inst_addr_ok=0; instruction is granted in the IDLE after data completes.
REQ-040 Reset asserted while in RD_DATA -> all outputs 0 immediately; next request is handled normally.
REQ-041 Without INST_PORT_EN, inst_req held high for 50 cycles -> inst_addr_ok stays 0 and no ARID=0 transaction is issued.
